// File: rtl/cordic_hyp_iter.sv
// Iterative hyperbolic CORDIC on sign-magnitude words: one micro-rotation per
// clock, shift index 1..ITERS with indices 4 and 13 executed twice.
module cordic_hyp_iter #(
  parameter int WIDTH = 32,
  parameter int ITERS = 16,
  parameter int IDXW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic [IDXW-1:0]  lut_idx,
  input  logic [WIDTH-1:0] lut_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic             ovf
);

  localparam int MW = WIDTH - 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ITERS);
  localparam logic [IDXW-1:0] REP_A    = IDXW'(4);
  localparam logic [IDXW-1:0] REP_B    = IDXW'(13);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx;
  logic            rep;
  logic            mode_r;
  logic            accept;
  logic            dup;
  logic            last;
  logic            dir_pos;
  logic [WIDTH:0]  x_sum, y_sum, z_sum;

  // Sign-magnitude add with magnitude saturation; returns {saturated, result}.
  // A zero magnitude always comes out with a positive sign.
  function automatic logic [WIDTH:0] sm_add(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [MW:0]   sum;
    logic [MW-1:0] mag;
    logic          sgn;
    logic          sat;
    sum = '0;
    sat = 1'b0;
    if (a[MW] == b[MW]) begin
      sum = {1'b0, a[MW-1:0]} + {1'b0, b[MW-1:0]};
      sgn = a[MW];
      if (sum[MW]) begin
        mag = '1;
        sat = 1'b1;
      end else begin
        mag = sum[MW-1:0];
      end
    end else if (a[MW-1:0] >= b[MW-1:0]) begin
      mag = a[MW-1:0] - b[MW-1:0];
      sgn = a[MW];
    end else begin
      mag = b[MW-1:0] - a[MW-1:0];
      sgn = b[MW];
    end
    if (mag == '0) sgn = 1'b0;
    return {sat, sgn, mag};
  endfunction

  // Shift the magnitude right, sign untouched.
  function automatic logic [WIDTH-1:0] sm_shr(input logic [WIDTH-1:0] a,
                                              input logic [IDXW-1:0]  sh);
    return {a[MW], a[MW-1:0] >> sh};
  endfunction

  // Conditionally negate by flipping the sign bit.
  function automatic logic [WIDTH-1:0] sm_flip(input logic [WIDTH-1:0] a,
                                               input logic             flip);
    return {a[MW] ^ flip, a[MW-1:0]};
  endfunction

  // Strictly negative: a negative zero counts as non-negative.
  function automatic logic sm_is_neg(input logic [WIDTH-1:0] a);
    return a[MW] & (|a[MW-1:0]);
  endfunction

  // Canonicalise negative zero to positive zero.
  function automatic logic [WIDTH-1:0] sm_clean(input logic [WIDTH-1:0] a);
    return (a[MW-1:0] == '0) ? '0 : a;
  endfunction

  assign accept  = start && (state == IDLE || state == DONE);
  assign dup     = (idx == REP_A || idx == REP_B) && !rep;
  assign last    = (idx == LAST_IDX) && !dup;
  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign lut_idx = (state == RUN) ? idx : '0;

  // Micro-rotation: direction and all three updates from current registers.
  always_comb begin
    dir_pos = mode_r ? !sm_is_neg(z_out) : sm_is_neg(y_out);
    x_sum   = sm_add(x_out, sm_flip(sm_shr(y_out, idx), !dir_pos));
    y_sum   = sm_add(y_out, sm_flip(sm_shr(x_out, idx), !dir_pos));
    z_sum   = sm_add(z_out, sm_flip(lut_val, dir_pos));
  end

  // Next-state logic for IDLE -> RUN -> DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: state, shift index sequencing, latched mode, sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      rep    <= 1'b0;
      mode_r <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx    <= IDXW'(1);
        rep    <= 1'b0;
        mode_r <= mode;
        ovf    <= 1'b0;
      end else if (state == RUN) begin
        ovf <= ovf | x_sum[WIDTH] | y_sum[WIDTH] | z_sum[WIDTH];
        if (dup) begin
          rep <= 1'b1;
        end else begin
          rep <= 1'b0;
          idx <= idx + IDXW'(1);
        end
      end
    end
  end

  // Datapath: operands loaded on accept, updated once per RUN cycle, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else if (accept) begin
      x_out <= sm_clean(x_in);
      y_out <= sm_clean(y_in);
      z_out <= sm_clean(z_in);
    end else if (state == RUN) begin
      x_out <= x_sum[WIDTH-1:0];
      y_out <= y_sum[WIDTH-1:0];
      z_out <= z_sum[WIDTH-1:0];
    end
  end

endmodule
